// File: rtl/membrane_integrator.sv
`timescale 1ns/1ps
// Membrane potential integrator: V += (I_ext - I_Na - I_K - I_L) >>> DT_SHIFT, Q8.8, clamped, with spike detection.
// Optional refractory suppression of spikes is enabled by defining MEMBRANE_INTEGRATOR_REFRACTORY_EN.
module membrane_integrator #(
    parameter int DT_SHIFT      = 4,
    parameter int V_REST        = -16640,
    parameter int V_MIN         = -25600,
    parameter int V_MAX         = 15360,
    parameter int SPIKE_THRESH  = 0,
    parameter int REFRACT_STEPS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_valid,
    input  logic signed [15:0] I_ext,
    input  logic signed [15:0] I_Na,
    input  logic signed [15:0] I_K,
    input  logic signed [15:0] I_L,
    output logic signed [15:0] V,
    output logic               v_valid,
    output logic               spike,
    output logic [15:0]        spike_count,
    output logic               busy,
    output logic               overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SUM    = 2'd1;
    localparam logic [1:0] S_SCALE  = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic signed [18:0] V_MIN_W  = 19'(V_MIN);
    localparam logic signed [18:0] V_MAX_W  = 19'(V_MAX);
    localparam logic signed [15:0] V_REST_W = 16'(V_REST);
    localparam logic signed [15:0] THRESH_W = 16'(SPIKE_THRESH);

    logic [1:0]         state;
    logic signed [15:0] i_ext_q, i_na_q, i_k_q, i_l_q;
    logic signed [17:0] i_net;
    logic signed [17:0] dv;
    logic signed [18:0] v_sum;
    logic signed [15:0] v_new;
    logic               crossing;
    logic               spike_gate;

    // Handshake: step_valid is a request with no ready; it is accepted only when busy is low,
    // otherwise it is dropped and overrun latches. v_valid marks the single cycle in which V is new.
    assign busy = (state != S_IDLE);

    always_comb begin
        v_sum = {{3{V[15]}}, V} + {dv[17], dv};
        v_new = v_sum[15:0];
        if (v_sum < V_MIN_W)
            v_new = V_MIN_W[15:0];
        else if (v_sum > V_MAX_W)
            v_new = V_MAX_W[15:0];
        crossing = (V < THRESH_W) && (v_new >= THRESH_W);
    end

`ifdef MEMBRANE_INTEGRATOR_REFRACTORY_EN
    localparam int RW = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
    logic [RW-1:0] refract_cnt;

    assign spike_gate = (refract_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refract_cnt <= '0;
        end else if (state == S_UPDATE) begin
            // A new spike reloads the window; otherwise each completed step counts it down.
            if (crossing && spike_gate)
                refract_cnt <= RW'(REFRACT_STEPS);
            else if (refract_cnt != '0)
                refract_cnt <= refract_cnt - 1'b1;
        end
    end
`else
    assign spike_gate = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            i_ext_q     <= '0;
            i_na_q      <= '0;
            i_k_q       <= '0;
            i_l_q       <= '0;
            i_net       <= '0;
            dv          <= '0;
            V           <= V_REST_W;
            v_valid     <= 1'b0;
            spike       <= 1'b0;
            spike_count <= '0;
            overrun     <= 1'b0;
        end else begin
            v_valid <= 1'b0;
            spike   <= 1'b0;
            if (step_valid && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (step_valid) begin
                        i_ext_q <= I_ext;
                        i_na_q  <= I_Na;
                        i_k_q   <= I_K;
                        i_l_q   <= I_L;
                        state   <= S_SUM;
                    end
                end
                S_SUM: begin
                    // 18 bits hold the worst case of four full-scale 16-bit terms.
                    i_net <= {{2{i_ext_q[15]}}, i_ext_q} - {{2{i_na_q[15]}}, i_na_q}
                           - {{2{i_k_q[15]}}, i_k_q} - {{2{i_l_q[15]}}, i_l_q};
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    dv    <= i_net >>> DT_SHIFT;
                    state <= S_UPDATE;
                end
                default: begin
                    V       <= v_new;
                    v_valid <= 1'b1;
                    if (crossing && spike_gate) begin
                        spike <= 1'b1;
                        if (spike_count != 16'hFFFF)
                            spike_count <= spike_count + 16'd1;
                    end
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membrane_integrator.sv
`timescale 1ns/1ps
// Self-checking bench for membrane_integrator: directed scenarios plus randomized steps
// checked against an arithmetic model of the membrane equation.
module tb_membrane_integrator;

    localparam int DT_SHIFT      = 4;
    localparam int V_REST        = -16640;
    localparam int V_MIN         = -25600;
    localparam int V_MAX         = 15360;
    localparam int SPIKE_THRESH  = 0;
    localparam int REFRACT_STEPS = 8;

    logic               clk;
    logic               rst;
    logic               step_valid;
    logic signed [15:0] I_ext, I_Na, I_K, I_L;
    logic signed [15:0] V;
    logic               v_valid, spike, busy, overrun;
    logic [15:0]        spike_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_v;
    int m_count;
    int m_refr;
    logic [15:0] exp_q[$];

    membrane_integrator #(
        .DT_SHIFT(DT_SHIFT), .V_REST(V_REST), .V_MIN(V_MIN), .V_MAX(V_MAX),
        .SPIKE_THRESH(SPIKE_THRESH), .REFRACT_STEPS(REFRACT_STEPS)
    ) dut (
        .clk(clk), .rst(rst), .step_valid(step_valid),
        .I_ext(I_ext), .I_Na(I_Na), .I_K(I_K), .I_L(I_L),
        .V(V), .v_valid(v_valid), .spike(spike), .spike_count(spike_count),
        .busy(busy), .overrun(overrun)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int floor_div(input int x, input int d);
        int q;
        q = x / d;
        if (x < 0 && q * d != x)
            q = q - 1;
        return q;
    endfunction

    function automatic int clamp_v(input int x);
        if (x < V_MIN) return V_MIN;
        if (x > V_MAX) return V_MAX;
        return x;
    endfunction

    task automatic model_reset();
        m_v     = V_REST;
        m_count = 0;
        m_refr  = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        step_valid = 1'b0;
        I_ext = '0; I_Na = '0; I_K = '0; I_L = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: one accepted step; checks latency, busy, V stability, result, spike and count.
    task automatic do_step(input int ie, input int ina, input int ik, input int il, input string tag);
        int inet, vn;
        bit sp_exp;
        logic [15:0] v_before, vexp;
        inet   = ie - ina - ik - il;
        vn     = clamp_v(m_v + floor_div(inet, 1 << DT_SHIFT));
        sp_exp = (m_v < SPIKE_THRESH) && (vn >= SPIKE_THRESH);
`ifdef MEMBRANE_INTEGRATOR_REFRACTORY_EN
        if (m_refr != 0) sp_exp = 1'b0;
        if (sp_exp) m_refr = REFRACT_STEPS;
        else if (m_refr > 0) m_refr = m_refr - 1;
`endif
        if (sp_exp && m_count < 65535) m_count = m_count + 1;
        m_v = vn;
        exp_q.push_back(16'(vn));

        v_before   = V;
        I_ext      = 16'(ie);
        I_Na       = 16'(ina);
        I_K        = 16'(ik);
        I_L        = 16'(il);
        step_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                step_valid = 1'b0;
                I_ext = 16'($urandom); I_Na = 16'($urandom);
                I_K   = 16'($urandom); I_L  = 16'($urandom);
            end
            checks++;
            if (k < 4) begin
                if (v_valid !== 1'b0 || busy !== 1'b1 || V !== v_before) begin
                    errors++;
                    $display("FAIL %s cycle%0d: v_valid=%b busy=%b V=%0d, want v_valid=0 busy=1 V=%0d",
                             tag, k, v_valid, busy, V, $signed(v_before));
                end
            end else begin
                vexp = exp_q.pop_front();
                if (v_valid !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s latency: v_valid=%b busy=%b want 1/0", tag, v_valid, busy);
                end
                checks++;
                if (V !== vexp) begin
                    errors++;
                    $display("FAIL %s V: got %0d want %0d", tag, V, $signed(vexp));
                end
                checks++;
                if (spike !== sp_exp || spike_count !== 16'(m_count)) begin
                    errors++;
                    $display("FAIL %s spike: got %b/%0d want %b/%0d", tag, spike, spike_count, sp_exp, m_count);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        step_valid = 1'b0;
        I_ext = '0; I_Na = '0; I_K = '0; I_L = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (V !== -16'sd16640 || v_valid !== 1'b0 || spike !== 1'b0 || busy !== 1'b0 ||
            overrun !== 1'b0 || spike_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: V=%0d vv=%b sp=%b busy=%b ovr=%b cnt=%0d", V, v_valid, spike,
                     busy, overrun, spike_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero_step();
        do_step(0, 0, 0, 0, "zero_step");
        checks++;
        if (V !== -16'sd16640 || spike !== 1'b0) begin
            errors++;
            $display("FAIL zero_step_const: V=%0d spike=%b want -16640/0", V, spike);
        end
    endtask

    task automatic test_small_step();
        do_reset();
        do_step(2560, 0, 0, 0, "small_step");
        checks++;
        if (V !== -16'sd16480) begin
            errors++;
            $display("FAIL small_step_const: V=%0d want -16480", V);
        end
    endtask

    task automatic test_depolarize();
        do_reset();
        for (int n = 1; n <= 18; n++) begin
            do_step(32767, 0, 0, 0, "depolarize");
            if (n == 8) begin
                checks++;
                if (V !== -16'sd264) begin
                    errors++;
                    $display("FAIL depol_step8: V=%0d want -264", V);
                end
            end
            if (n == 9) begin
                checks++;
                if (V !== 16'sd1783 || spike !== 1'b1 || spike_count !== 16'd1) begin
                    errors++;
                    $display("FAIL depol_step9: V=%0d spike=%b cnt=%0d want 1783/1/1", V, spike, spike_count);
                end
            end
            if (n == 10) begin
                checks++;
                if (spike !== 1'b0) begin
                    errors++;
                    $display("FAIL depol_step10: spike=%b want 0", spike);
                end
            end
            if (n >= 16) begin
                checks++;
                if (V !== 16'sd15360 || spike_count !== 16'd1) begin
                    errors++;
                    $display("FAIL depol_clamp: V=%0d cnt=%0d want 15360/1", V, spike_count);
                end
            end
        end
    endtask

    task automatic test_hyperpolarize();
        int prev;
        do_reset();
        prev = V_REST;
        for (int n = 1; n <= 7; n++) begin
            do_step(0, 0, 32767, 0, "hyperpolarize");
            checks++;
            if (n <= 4) begin
                if (int'(V) !== prev - 2048) begin
                    errors++;
                    $display("FAIL hyper_step%0d: V=%0d want %0d", n, V, prev - 2048);
                end
            end else if (V !== -16'sd25600) begin
                errors++;
                $display("FAIL hyper_clamp%0d: V=%0d want -25600", n, V);
            end
            prev = int'(V);
        end
    endtask

    task automatic test_overrun();
        int vv_count;
        do_reset();
        vv_count = 0;
        I_ext = 16'sd2560;
        step_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            step_valid = (k == 2);
            if (k == 1) I_ext = 16'sd5000;
            if (v_valid === 1'b1) vv_count++;
        end
        checks++;
        if (vv_count != 1 || overrun !== 1'b1 || V !== -16'sd16480) begin
            errors++;
            $display("FAIL overrun: v_valid_pulses=%0d ovr=%b V=%0d want 1/1/-16480", vv_count, overrun, V);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%b want 1", overrun);
        end
        do_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid_step();
        int vv_count;
        do_reset();
        vv_count = 0;
        I_ext = 16'sd2560;
        step_valid = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || V !== -16'sd16640 || v_valid !== 1'b0) begin
            errors++;
            $display("FAIL midstep_reset: busy=%b V=%0d vv=%b want 0/-16640/0", busy, V, v_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (v_valid === 1'b1) vv_count++;
        end
        checks++;
        if (vv_count != 0 || V !== -16'sd16640 || spike_count !== 16'd0) begin
            errors++;
            $display("FAIL midstep_discard: v_valid_pulses=%0d V=%0d cnt=%0d want 0/-16640/0", vv_count, V,
                     spike_count);
        end
        model_reset();
    endtask

    task automatic test_random_back_to_back();
        logic signed [15:0] r0, r1, r2, r3;
        for (int n = 0; n < 40; n++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom_range(0, 8191));
            r2 = 16'($urandom_range(0, 8191));
            r3 = 16'($urandom);
            do_step(int'(r0), int'(r1), int'(r2), int'(r3), "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        step_valid = 1'b0;
        I_ext = '0; I_Na = '0; I_K = '0; I_L = '0;
        model_reset();
        test_reset();
        test_zero_step();
        test_small_step();
        test_depolarize();
        test_hyperpolarize();
        test_overrun();
        test_reset_mid_step();
        test_random_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
